// File: rtl/vga_tile_scanner.sv
// Purpose: 640x480@60 raster front end; walks the 80x60 grid of 8x8 tiles, fetches tile codes from VRAM and drives VGA pins.
// Latency: 2 pixel-enables from counter position to pins, identical for colour and sync.
// Backpressure: none; free-running raster, VRAM and decoder must answer within one pixel period.
//
// Ports: clk/rst (sync, active-high); vram_addr/vram_data tile fetch; dec_num/dec_x/dec_y to the
// colour decoder and dec_data back from it; vga_r/g/b, vga_hs/vga_vs (active low) pins;
// frame_start one-clk pulse when position (0,0) is taken into the pipeline.
module vga_tile_scanner #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int TILES_X  = 80
) (
    input  logic        clk,
    input  logic        rst,
    output logic [12:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [7:0]  dec_num,
    output logic [2:0]  dec_x,
    output logic [2:0]  dec_y,
    input  logic [11:0] dec_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam logic [12:0] TILE_MUL = 13'(TILES_X);
    localparam logic [7:0]  BG_CODE  = 8'h09;

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [H_W-1:0]   h;
    logic [V_W-1:0]   v;
    logic             active0;
    logic             hs0;
    logic             vs0;
    logic [12:0]      tile_addr;
    logic [2:0]       h1;
    logic [2:0]       v1;
    logic             active1;
    logic             hs1;
    logic             vs1;

    // Row base = tile_row * TILES_X built only from shifted adds of the set bits
    // of the constant (80 -> row<<6 + row<<4), so no multiplier is inferred.
    function automatic logic [12:0] times_tiles_x(input logic [12:0] row);
        logic [12:0] acc;
        acc = '0;
        for (int i = 0; i < 13; i++) begin
            if (TILE_MUL[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

    // With CLK_DIV=1 div is a single bit held at 0, so pix_en is constantly high.
    assign pix_en = (div == DIV_W'(CLK_DIV - 1));

    // Stage 0 decode: line/frame order is active, front porch, sync, back porch.
    always_comb begin
        active0   = (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));
        hs0       = !((h >= H_W'(H_ACTIVE + H_FP)) && (h < H_W'(H_ACTIVE + H_FP + H_SYNC)));
        vs0       = !((v >= V_W'(V_ACTIVE + V_FP)) && (v < V_W'(V_ACTIVE + V_FP + V_SYNC)));
        tile_addr = times_tiles_x(13'(v >> 3)) + 13'(h >> 3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (pix_en) begin
            div <= '0;
            if (h == H_W'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    // Stage 1/2 pipeline. Sync is carried through the same two registers as the
    // colour so hs/vs stay aligned with the pixel they belong to on the pins.
    // Stage-1 sync copies reset to the inactive (high) level so pins never glitch low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vram_addr   <= '0;
            h1          <= '0;
            v1          <= '0;
            active1     <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            // Pulses in the clk after the pixel edge that moves (0,0) into stage 1;
            // on non-pixel edges pix_en is low so the pulse is exactly one clk wide.
            frame_start <= pix_en && (h == '0) && (v == '0);
            if (pix_en) begin
                vram_addr <= active0 ? tile_addr : '0;
                h1        <= h[2:0];
                v1        <= v[2:0];
                active1   <= active0;
                hs1       <= hs0;
                vs1       <= vs0;
                {vga_r, vga_g, vga_b} <= active1 ? dec_data : 12'h000;
                vga_hs    <= hs1;
                vga_vs    <= vs1;
            end
        end
    end

    // Blanking feeds the decoder the background code; the pins are forced black anyway.
    assign dec_num = active1 ? vram_data : BG_CODE;
    assign dec_x   = h1;
    assign dec_y   = v1;

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Purpose: scoreboard bench for vga_tile_scanner at CLK_DIV=4 and CLK_DIV=1, shortened frame height.
// Latency: expected pin state pushed at each clock edge, popped and compared on the following negedge.
// Backpressure: none; the raster free-runs and every clock is checked.
module tb_vga_tile_scanner;
    // Horizontal timing at defaults (800 px/line); 16 lines per frame:
    // 12 active, 1 front porch, 2 sync (lines 13..14), 1 back porch.
    localparam int FRAME     = 800 * 16;
    localparam int CLK_LIMIT = 80000;

    typedef struct {
        int          n;
        bit          pe;
        logic [41:0] v;
    } exp_t;

    logic        clk;
    logic        rst         [2];
    logic [12:0] vram_addr   [2];
    logic [7:0]  vram_data   [2];
    logic [7:0]  dec_num     [2];
    logic [2:0]  dec_x       [2];
    logic [2:0]  dec_y       [2];
    logic [11:0] dec_data    [2];
    logic [3:0]  vga_r       [2];
    logic [3:0]  vga_g       [2];
    logic [3:0]  vga_b       [2];
    logic        vga_hs      [2];
    logic        vga_vs      [2];
    logic        frame_start [2];

    int   n_cmp;
    int   n_bad;
    int   clk_cnt;
    bit   abort;
    bit   done [2];
    int   cdiv [2];
    int   npix [2];
    exp_t q [2][$];

    bit   prev_hs [2];
    bit   prev_vs [2];
    bit   seen_fall [2];
    int   last_fall [2];
    int   low_clks [2];
    int   vs_pix [2];

    function automatic int cd_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int hp(input int p);
        return p % 800;
    endfunction

    function automatic int vp(input int p);
        return p / 800;
    endfunction

    function automatic bit act_of(input int p);
        return (hp(p) < 640) && (vp(p) < 12);
    endfunction

    function automatic logic hs_of(input int p);
        return !((hp(p) >= 656) && (hp(p) < 752));
    endfunction

    function automatic logic vs_of(input int p);
        return !((vp(p) >= 13) && (vp(p) < 15));
    endfunction

    function automatic logic [12:0] addr_of(input int p);
        if (!act_of(p)) return 13'd0;
        return 13'((vp(p) / 8) * 80 + hp(p) / 8);
    endfunction

    // VRAM contents: code 3 at address 82, elsewhere low byte with bit 4 set
    // (never the background code 9).
    function automatic logic [7:0] vram_code(input logic [12:0] a);
        if (a == 13'd82) return 8'h03;
        return a[7:0] | 8'h10;
    endfunction

    // Decoder: white for the background code, 12'h18b for code 3 at (1,1).
    function automatic logic [11:0] dec_fn(input logic [7:0] code, input logic [2:0] x, input logic [2:0] y);
        if (code == 8'h09) return 12'hfff;
        if (code == 8'h03 && x == 3'd1 && y == 3'd1) return 12'h18b;
        return {code[3:0], 1'b0, x, 1'b0, y};
    endfunction

    // Expected {addr, dec_num, dec_x, dec_y, rgb, hs, vs, frame_start} after n pixel edges.
    function automatic logic [41:0] expect_at(input int n, input bit pe);
        logic [12:0] a;
        logic [7:0]  num;
        logic [2:0]  x;
        logic [2:0]  y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        int          p1;
        int          p2;
        a = '0; num = 8'h09; x = '0; y = '0; rgb = '0; hs = 1'b1; vs = 1'b1; fs = 1'b0;
        if (n >= 1) begin
            p1  = (n - 1) % FRAME;
            a   = addr_of(p1);
            num = act_of(p1) ? vram_code(a) : 8'h09;
            x   = 3'(hp(p1) % 8);
            y   = 3'(vp(p1) % 8);
            fs  = pe && (p1 == 0);
        end
        if (n >= 2) begin
            p2  = (n - 2) % FRAME;
            hs  = hs_of(p2);
            vs  = vs_of(p2);
            rgb = act_of(p2) ? dec_fn(vram_code(addr_of(p2)), 3'(hp(p2) % 8), 3'(vp(p2) % 8)) : 12'h000;
        end
        return {a, num, x, y, rgb, hs, vs, fs};
    endfunction

    vga_tile_scanner #(.CLK_DIV(4), .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_div4 (
        .clk(clk), .rst(rst[0]), .vram_addr(vram_addr[0]), .vram_data(vram_data[0]),
        .dec_num(dec_num[0]), .dec_x(dec_x[0]), .dec_y(dec_y[0]), .dec_data(dec_data[0]),
        .vga_r(vga_r[0]), .vga_g(vga_g[0]), .vga_b(vga_b[0]),
        .vga_hs(vga_hs[0]), .vga_vs(vga_vs[0]), .frame_start(frame_start[0])
    );

    vga_tile_scanner #(.CLK_DIV(1), .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_div1 (
        .clk(clk), .rst(rst[1]), .vram_addr(vram_addr[1]), .vram_data(vram_data[1]),
        .dec_num(dec_num[1]), .dec_x(dec_x[1]), .dec_y(dec_y[1]), .dec_data(dec_data[1]),
        .vga_r(vga_r[1]), .vga_g(vga_g[1]), .vga_b(vga_b[1]),
        .vga_hs(vga_hs[1]), .vga_vs(vga_vs[1]), .frame_start(frame_start[1])
    );

    assign vram_data[0] = vram_code(vram_addr[0]);
    assign vram_data[1] = vram_code(vram_addr[1]);
    assign dec_data[0]  = dec_fn(dec_num[0], dec_x[0], dec_y[0]);
    assign dec_data[1]  = dec_fn(dec_num[1], dec_x[1], dec_y[1]);

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input int n, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s div=%0d pix=%0d got=%0h want=%0h", nm, cd_of(i), n, act, want);
        end
    endtask

    // Reference: pixel-edge count since reset release, expected state pushed per clock.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            if (rst[i]) begin
                cdiv[i] = 0;
                npix[i] = 0;
                e.pe    = 1'b0;
            end else begin
                e.pe = (cdiv[i] == cd_of(i) - 1);
                if (e.pe) begin
                    npix[i]++;
                    cdiv[i] = 0;
                end else begin
                    cdiv[i]++;
                end
            end
            e.n = npix[i];
            e.v = expect_at(npix[i], e.pe);
            q[i].push_back(e);
        end
    end

    // Monitor: full compare every clock, plus hand-computed points and sync timing.
    always @(negedge clk) begin
        clk_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0) begin
                exp_t        e;
                logic [41:0] a;
                e = q[i].pop_front();
                a = {vram_addr[i], dec_num[i], dec_x[i], dec_y[i], vga_r[i], vga_g[i], vga_b[i],
                     vga_hs[i], vga_vs[i], frame_start[i]};
                chk("pins", i, e.n, 64'(a), 64'(e.v));
                if (e.pe) begin
                    if (e.n == 1)     chk("fs_after_reset", i, e.n, 64'(frame_start[i]), 64'd1);
                    if (e.n == 7218) begin
                        chk("addr_h17_v9", i, e.n, 64'(vram_addr[i]), 64'd82);
                        chk("dec_num_82", i, e.n, 64'(dec_num[i]), 64'h03);
                        chk("dec_xy", i, e.n, 64'({dec_x[i], dec_y[i]}), 64'b001001);
                    end
                    if (e.n == 7219)  chk("rgb_18b", i, e.n, 64'({vga_r[i], vga_g[i], vga_b[i]}), 64'h18b);
                    if (e.n == 9440)  chk("addr_last_vis", i, e.n, 64'(vram_addr[i]), 64'd159);
                    if (e.n == 9441) begin
                        chk("addr_h640", i, e.n, 64'(vram_addr[i]), 64'd0);
                        chk("dec_num_blank", i, e.n, 64'(dec_num[i]), 64'h09);
                    end
                    if (e.n == 12801) chk("fs_wrap", i, e.n, 64'(frame_start[i]), 64'd1);
                end
                if (e.n == 0) begin
                    seen_fall[i] = 1'b0;
                    prev_hs[i]   = 1'b1;
                    prev_vs[i]   = 1'b1;
                    low_clks[i]  = 0;
                    vs_pix[i]    = 0;
                end else begin
                    if (prev_hs[i] && !vga_hs[i]) begin
                        if (!seen_fall[i]) chk("hs_first_fall", i, e.n, 64'(e.n), 64'd658);
                        else chk("line_period", i, e.n, 64'(clk_cnt - last_fall[i]), 64'(800 * cd_of(i)));
                        seen_fall[i] = 1'b1;
                        last_fall[i] = clk_cnt;
                        low_clks[i]  = 0;
                    end
                    if (!prev_hs[i] && vga_hs[i]) chk("hs_low_clks", i, e.n, 64'(low_clks[i]), 64'(96 * cd_of(i)));
                    if (!vga_hs[i]) low_clks[i]++;
                    if (prev_vs[i] && !vga_vs[i]) vs_pix[i] = 0;
                    if (!prev_vs[i] && vga_vs[i]) chk("vs_low_pix", i, e.n, 64'(vs_pix[i]), 64'd1600);
                    if (!vga_vs[i] && e.pe) vs_pix[i]++;
                    prev_hs[i] = vga_hs[i];
                    prev_vs[i] = vga_vs[i];
                end
            end
        end
        if (clk_cnt == CLK_LIMIT && !(done[0] && done[1])) begin
            chk("timeout", 0, clk_cnt, 64'(done[0] && done[1]), 64'd1);
            abort = 1'b1;
        end
    end

    task automatic wait_pix(input int i, input int target);
        while (npix[i] != target && !abort) @(negedge clk);
    endtask

    // Reset 3 clks, run a full frame and into the next up to (300,1), reset for
    // one clk mid-line, then run past the first hsync fall of the restarted frame.
    task automatic run_seq(input int i);
        rst[i] = 1'b1;
        repeat (3) @(negedge clk);
        rst[i] = 1'b0;
        wait_pix(i, FRAME + 1100);
        rst[i] = 1'b1;
        @(negedge clk);
        rst[i] = 1'b0;
        wait_pix(i, 1000);
        done[i] = 1'b1;
    endtask

    initial begin
        clk    = 1'b0;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        fork
            run_seq(0);
            run_seq(1);
        join
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
